// File: rtl/cache_snoop_responder_pkg.sv
// Shared bus/MESI/message types for the L2 snoop path, plus snoop-result and responder FSM enums.
package cache_snoop_responder_pkg;

   typedef enum logic [2:0] {NULL, READ, WRITE, INVALIDATE, RWIM} bus_struct;
   typedef enum logic [1:0] {I, S, E, M} mesi_struct;
   typedef enum logic [1:0] {N_NULL, SNOOP_READ_REQ, SNOOP_READ_WITH_M, SNOOP_INVALID_CMD} n_struct;

   typedef enum logic [1:0] {NOHIT, HIT, HITM} snoop_t;
   typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_RESPOND, ST_WRITEBACK, ST_NOTIFY} resp_state_t;

   // Ops that pull the line's data to another cache.
   function automatic logic is_read_like(input bus_struct op);
      return (op == READ) || (op == RWIM);
   endfunction

endpackage

// File: rtl/cache_snoop_responder_decode.sv
// Combinational snoop decode: (op, hit, MESI state) -> snoop result, message and follow-up actions.
module cache_snoop_decode
   import cache_snoop_responder_pkg::*;
(
   input  bus_struct  op_i,
   input  logic       hit_i,
   input  mesi_struct state_i,
   output snoop_t     snoop_o,
   output n_struct    msg_o,
   output logic       need_wb_o,
   output logic       need_notify_o,
   output logic       proto_err_set_o
);

   always_comb begin
      snoop_o         = NOHIT;
      msg_o           = N_NULL;
      need_wb_o       = 1'b0;
      need_notify_o   = 1'b0;
      proto_err_set_o = 1'b0;

      // A snooped WRITE never hits: only the owning cache writes the line back.
      if (hit_i && (state_i != I) && (op_i != WRITE) && (op_i != NULL)) begin
         snoop_o = (state_i == M) ? HITM : HIT;
      end

      case (op_i)
         READ:       msg_o = SNOOP_READ_REQ;
         RWIM:       msg_o = SNOOP_READ_WITH_M;
         INVALIDATE: msg_o = SNOOP_INVALID_CMD;
         default:    msg_o = N_NULL;
      endcase

      need_notify_o   = (snoop_o != NOHIT) && (msg_o != N_NULL);
      need_wb_o       = (snoop_o == HITM) && is_read_like(op_i);
      proto_err_set_o = (snoop_o == HITM) && (op_i == INVALIDATE);
   end

endmodule

// File: rtl/cache_snoop_responder.sv
// Answers bus ops snooped from other caches: tag lookup, snoop result, optional writeback, MESI message.
module cache_snoop_responder
   import cache_snoop_responder_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int LOOKUP_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              snp_valid,
   input  bus_struct         snp_op,
   input  logic [ADDR_W-1:0] snp_addr,
   output logic              snp_ready,
   output logic              lk_req,
   output logic [ADDR_W-1:0] lk_addr,
   input  logic              lk_ack,
   input  logic              lk_hit,
   input  mesi_struct        lk_state,
   output logic              rsp_valid,
   output logic              C_out,
   output logic              hitm_out,
   output logic              wb_req,
   input  logic              wb_done,
   output logic              nmsg_valid,
   output n_struct           nmsg_out,
   output logic              lk_timeout,
   output logic              proto_err
);

   localparam int TO_W = $clog2(LOOKUP_TIMEOUT + 1);

   resp_state_t       state_q, state_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   bus_struct         op_q;
   logic [ADDR_W-1:0] addr_q;
   n_struct           msg_q;
   logic              need_wb_q, need_notify_q;
   logic              snp_ready_q, lk_req_q, rsp_valid_q, c_q, hitm_q, wb_req_q;
   logic              nmsg_valid_q, lk_timeout_q, proto_err_q;
   n_struct           nmsg_q;

   logic              accept, lk_done, to_set;
   snoop_t            dec_snoop;
   n_struct           dec_msg;
   logic              dec_wb, dec_notify, dec_perr;

   // A timed-out lookup has lk_ack low, so the decode sees a miss.
   cache_snoop_decode u_decode (
      .op_i            (op_q),
      .hit_i           (lk_ack & lk_hit),
      .state_i         (lk_state),
      .snoop_o         (dec_snoop),
      .msg_o           (dec_msg),
      .need_wb_o       (dec_wb),
      .need_notify_o   (dec_notify),
      .proto_err_set_o (dec_perr)
   );

   assign accept = (state_q == ST_IDLE) && snp_valid && (snp_op != NULL);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lk_done = 1'b0;
      to_set  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            cnt_d = cnt_q + 1'b1;
            if (lk_ack) begin
               lk_done = 1'b1;
               state_d = ST_RESPOND;
            end else if (cnt_d == TO_W'(LOOKUP_TIMEOUT)) begin
               lk_done = 1'b1;
               to_set  = 1'b1;
               state_d = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            if (need_wb_q)          state_d = ST_WRITEBACK;
            else if (need_notify_q) state_d = ST_NOTIFY;
            else                    state_d = ST_IDLE;
         end
         ST_WRITEBACK: if (wb_done) state_d = ST_NOTIFY;
         ST_NOTIFY:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each strobe lines up with its state.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         op_q          <= NULL;
         addr_q        <= '0;
         msg_q         <= N_NULL;
         need_wb_q     <= 1'b0;
         need_notify_q <= 1'b0;
         snp_ready_q   <= 1'b1;
         lk_req_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         c_q           <= 1'b0;
         hitm_q        <= 1'b0;
         wb_req_q      <= 1'b0;
         nmsg_valid_q  <= 1'b0;
         nmsg_q        <= N_NULL;
         lk_timeout_q  <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            op_q   <= snp_op;
            addr_q <= snp_addr;
         end
         if (lk_done) begin
            msg_q         <= dec_msg;
            need_wb_q     <= dec_wb;
            need_notify_q <= dec_notify;
         end
         snp_ready_q  <= (state_d == ST_IDLE);
         lk_req_q     <= (state_d == ST_LOOKUP);
         rsp_valid_q  <= (state_d == ST_RESPOND);
         c_q          <= lk_done && (dec_snoop != NOHIT);
         hitm_q       <= lk_done && (dec_snoop == HITM);
         wb_req_q     <= (state_d == ST_WRITEBACK);
         nmsg_valid_q <= (state_d == ST_NOTIFY);
         nmsg_q       <= (state_d == ST_NOTIFY) ? msg_q : N_NULL;
         lk_timeout_q <= lk_timeout_q | to_set;
         proto_err_q  <= proto_err_q | (lk_done & dec_perr);
      end
   end

   assign snp_ready  = snp_ready_q;
   assign lk_req     = lk_req_q;
   assign lk_addr    = addr_q;
   assign rsp_valid  = rsp_valid_q;
   assign C_out      = c_q;
   assign hitm_out   = hitm_q;
   assign wb_req     = wb_req_q;
   assign nmsg_valid = nmsg_valid_q;
   assign nmsg_out   = nmsg_q;
   assign lk_timeout = lk_timeout_q;
   assign proto_err  = proto_err_q;

endmodule
